// File: rtl/int_alu_rs_if.sv
// Dispatch, writeback, issue and back-pressure bundle between the integer ALU
// reservation station (slave) and its surroundings (master).
interface int_alu_rs_if #(
    parameter int DEPTH          = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int R_ADDR         = 6,
    parameter int ROB_INDEX_BITS = 3
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic                      flush;
    logic                      disp_valid;
    logic                      disp_ready;
    logic [4:0]                disp_microop;
    logic [R_ADDR-1:0]         disp_dest;
    logic [ROB_INDEX_BITS-1:0] disp_ticket;
    logic [DATA_WIDTH-1:0]     disp_data1;
    logic [DATA_WIDTH-1:0]     disp_data2;
    logic                      disp_rdy1;
    logic                      disp_rdy2;
    logic [R_ADDR-1:0]         disp_src1;
    logic [R_ADDR-1:0]         disp_src2;
    logic                      wb_valid;
    logic [R_ADDR-1:0]         wb_dest;
    logic [DATA_WIDTH-1:0]     wb_data;
    logic                      busy_fu;
    logic                      iss_valid;
    logic [4:0]                iss_microop;
    logic [R_ADDR-1:0]         iss_dest;
    logic [ROB_INDEX_BITS-1:0] iss_ticket;
    logic [DATA_WIDTH-1:0]     iss_data1;
    logic [DATA_WIDTH-1:0]     iss_data2;
    logic [OCC_W-1:0]          occupancy;

    modport master (
        output flush, disp_valid, disp_microop, disp_dest, disp_ticket,
               disp_data1, disp_data2, disp_rdy1, disp_rdy2, disp_src1, disp_src2,
               wb_valid, wb_dest, wb_data, busy_fu,
        input  disp_ready, iss_valid, iss_microop, iss_dest, iss_ticket,
               iss_data1, iss_data2, occupancy
    );

    modport slave (
        input  flush, disp_valid, disp_microop, disp_dest, disp_ticket,
               disp_data1, disp_data2, disp_rdy1, disp_rdy2, disp_src1, disp_src2,
               wb_valid, wb_dest, wb_data, busy_fu,
        output disp_ready, iss_valid, iss_microop, iss_dest, iss_ticket,
               iss_data1, iss_data2, occupancy
    );
endinterface

// File: rtl/int_alu_rs.sv
// Integer ALU reservation station: collapsing queue (index 0 oldest) that wakes
// operands from the writeback bus and issues the oldest ready op through a register.
module int_alu_rs #(
    parameter int DEPTH          = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int R_ADDR         = 6,
    parameter int ROB_INDEX_BITS = 3
) (
    input  logic         clk,
    input  logic         rst,
    int_alu_rs_if.slave  io
);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic                      valid;
        logic [4:0]                microop;
        logic [R_ADDR-1:0]         dest;
        logic [ROB_INDEX_BITS-1:0] ticket;
        logic                      rdy1;
        logic [R_ADDR-1:0]         src1;
        logic [DATA_WIDTH-1:0]     data1;
        logic                      rdy2;
        logic [R_ADDR-1:0]         src2;
        logic [DATA_WIDTH-1:0]     data2;
    } ent_t;

    typedef struct packed {
        logic                      valid;
        logic [4:0]                microop;
        logic [R_ADDR-1:0]         dest;
        logic [ROB_INDEX_BITS-1:0] ticket;
        logic [DATA_WIDTH-1:0]     data1;
        logic [DATA_WIDTH-1:0]     data2;
    } iss_t;

    ent_t [DEPTH-1:0] ent_q, ent_d;
    ent_t [DEPTH:0]   woken;   // extra top slot is an empty entry shifted in on issue
    ent_t             new_ent;
    iss_t             iss_q, iss_d;
    logic [OCC_W-1:0] occ_q, occ_d, wr_idx;
    logic [IDX_W-1:0] sel;
    logic             found, do_iss, disp_acc;

    assign io.disp_ready  = (occ_q < OCC_W'(DEPTH));
    assign io.occupancy   = occ_q;
    assign io.iss_valid   = iss_q.valid;
    assign io.iss_microop = iss_q.microop;
    assign io.iss_dest    = iss_q.dest;
    assign io.iss_ticket  = iss_q.ticket;
    assign io.iss_data1   = iss_q.data1;
    assign io.iss_data2   = iss_q.data2;

    assign disp_acc = io.disp_valid & io.disp_ready;

    // Oldest ready entry, from registered state only so a wakeup costs one cycle.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2) begin
                found = 1'b1;
                sel   = IDX_W'(i);
            end
        end
        do_iss = found & ~io.busy_fu;
    end

    always_comb begin
        woken = '0;
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = ent_q[i];
            if (ent_q[i].valid && !ent_q[i].rdy1 && io.wb_valid && ent_q[i].src1 == io.wb_dest) begin
                woken[i].rdy1  = 1'b1;
                woken[i].data1 = io.wb_data;
            end
            if (ent_q[i].valid && !ent_q[i].rdy2 && io.wb_valid && ent_q[i].src2 == io.wb_dest) begin
                woken[i].rdy2  = 1'b1;
                woken[i].data2 = io.wb_data;
            end
        end

        new_ent         = '0;
        new_ent.valid   = 1'b1;
        new_ent.microop = io.disp_microop;
        new_ent.dest    = io.disp_dest;
        new_ent.ticket  = io.disp_ticket;
        new_ent.src1    = io.disp_src1;
        new_ent.src2    = io.disp_src2;
        new_ent.rdy1    = io.disp_rdy1;
        new_ent.rdy2    = io.disp_rdy2;
        new_ent.data1   = io.disp_data1;
        new_ent.data2   = io.disp_data2;
        if (!io.disp_rdy1 && io.wb_valid && io.disp_src1 == io.wb_dest) begin
            new_ent.rdy1  = 1'b1;
            new_ent.data1 = io.wb_data;
        end
        if (!io.disp_rdy2 && io.wb_valid && io.disp_src2 == io.wb_dest) begin
            new_ent.rdy2  = 1'b1;
            new_ent.data2 = io.wb_data;
        end
    end

    always_comb begin
        wr_idx = occ_q - OCC_W'(do_iss);
        occ_d  = occ_q + OCC_W'(disp_acc) - OCC_W'(do_iss);
        ent_d  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (do_iss && IDX_W'(i) >= sel) ent_d[i] = woken[i + 1];
            else                            ent_d[i] = woken[i];
            if (disp_acc && OCC_W'(i) == wr_idx) ent_d[i] = new_ent;
        end

        iss_d = '0;
        if (do_iss) begin
            iss_d.valid   = 1'b1;
            iss_d.microop = ent_q[sel].microop;
            iss_d.dest    = ent_q[sel].dest;
            iss_d.ticket  = ent_q[sel].ticket;
            iss_d.data1   = ent_q[sel].data1;
            iss_d.data2   = ent_q[sel].data2;
        end

        if (io.flush) begin
            ent_d = '0;
            occ_d = '0;
            iss_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_q <= '0;
            iss_q <= '0;
            occ_q <= '0;
        end else begin
            ent_q <= ent_d;
            iss_q <= iss_d;
            occ_q <= occ_d;
        end
    end
endmodule
